// File: rtl/scs8hd_buf_pipe.sv
`default_nettype none
// ============================================================================
// Module   : scs8hd_buf_pipe
// Function : ready/valid FIFO buffer, DEPTH entries, one-cycle latency.
// Revision : 1.0
// ============================================================================
module scs8hd_buf_pipe #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 2,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] A,
   input  logic             a_valid,
   output logic             a_ready,
   output logic [WIDTH-1:0] X,
   output logic             x_valid,
   input  logic             x_ready,
   output logic [CW-1:0]    count
);

   localparam int                c_PTR_W    = $clog2(DEPTH);
   localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(DEPTH - 1);
   localparam logic [CW-1:0]      c_FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [CW-1:0]      r_count;

   logic               w_push;
   logic               w_pop;

   // Handshake flags depend only on the registered count.
   assign a_ready = (r_count < c_FULL_CNT);
   assign x_valid = (r_count != '0);
   assign X       = x_valid ? r_mem[r_rd_ptr] : '0;
   assign count   = r_count;

   assign w_push  = a_valid & a_ready;
   assign w_pop   = x_valid & x_ready;

   function automatic logic [c_PTR_W-1:0] next_ptr(input logic [c_PTR_W-1:0] ptr);
      return (ptr == c_LAST_PTR) ? '0 : ptr + c_PTR_W'(1);
   endfunction

   // Storage is not reset; stale entries are masked by x_valid.
   always_ff @(posedge clk) begin
      if (!reset && w_push) begin
         r_mem[r_wr_ptr] <= A;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= next_ptr(r_wr_ptr);
         end
         if (w_pop) begin
            r_rd_ptr <= next_ptr(r_rd_ptr);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_scs8hd_buf_pipe.sv
`default_nettype none
// Self-checking bench for scs8hd_buf_pipe: directed table, corner sequences,
// and randomized traffic against a queue model.
module tb_scs8hd_buf_pipe;

   logic       clk = 1'b0;
   logic       reset;

   // WIDTH=8, DEPTH=4
   logic [7:0] a8;
   logic       av8, xr8;
   logic       ar8, xv8;
   logic [7:0] x8;
   logic [2:0] cnt8;

   // WIDTH=8, DEPTH=3
   logic [7:0] a3;
   logic       av3, xr3;
   logic       ar3, xv3;
   logic [7:0] x3;
   logic [1:0] cnt3;

   // WIDTH=1, DEPTH=2
   logic       a1;
   logic       av1, xr1;
   logic       ar1, xv1;
   logic       x1;
   logic [1:0] cnt1;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   scs8hd_buf_pipe #(.WIDTH(8), .DEPTH(4)) u_dut (
      .clk(clk), .reset(reset), .A(a8), .a_valid(av8), .a_ready(ar8),
      .X(x8), .x_valid(xv8), .x_ready(xr8), .count(cnt8)
   );

   scs8hd_buf_pipe #(.WIDTH(8), .DEPTH(3)) u_dut3 (
      .clk(clk), .reset(reset), .A(a3), .a_valid(av3), .a_ready(ar3),
      .X(x3), .x_valid(xv3), .x_ready(xr3), .count(cnt3)
   );

   scs8hd_buf_pipe #(.WIDTH(1), .DEPTH(2)) u_dut1 (
      .clk(clk), .reset(reset), .A(a1), .a_valid(av1), .a_ready(ar1),
      .X(x1), .x_valid(xv1), .x_ready(xr1), .count(cnt1)
   );

   typedef struct {
      logic       rst;
      logic       av;
      logic [7:0] a;
      logic       xr;
      logic [2:0] e_cnt;
      logic       e_xv;
      logic [7:0] e_x;
      logic       e_ar;
   } vec_t;

   vec_t tbl[14];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] q3[$];
      logic       m_push, m_pop;

      reset = 1'b1;
      a8 = '0; av8 = 1'b0; xr8 = 1'b0;
      a3 = '0; av3 = 1'b0; xr3 = 1'b0;
      a1 = 1'b0; av1 = 1'b0; xr1 = 1'b0;
      tick();
      tick();
      reset = 1'b0;

      // rst, av, A, xr  ->  count, x_valid, X, a_ready (after the edge)
      tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b1};
      tbl[1]  = '{1'b0, 1'b1, 8'h11, 1'b0, 3'd1, 1'b1, 8'h11, 1'b1};
      tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 3'd1, 1'b1, 8'h11, 1'b1};
      tbl[3]  = '{1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b1};
      tbl[4]  = '{1'b0, 1'b1, 8'hA0, 1'b0, 3'd1, 1'b1, 8'hA0, 1'b1};
      tbl[5]  = '{1'b0, 1'b1, 8'hA1, 1'b0, 3'd2, 1'b1, 8'hA0, 1'b1};
      tbl[6]  = '{1'b0, 1'b1, 8'hA2, 1'b0, 3'd3, 1'b1, 8'hA0, 1'b1};
      tbl[7]  = '{1'b0, 1'b1, 8'hA3, 1'b0, 3'd4, 1'b1, 8'hA0, 1'b0};
      tbl[8]  = '{1'b0, 1'b1, 8'hA4, 1'b0, 3'd4, 1'b1, 8'hA0, 1'b0};
      tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd3, 1'b1, 8'hA1, 1'b1};
      tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd2, 1'b1, 8'hA2, 1'b1};
      tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd1, 1'b1, 8'hA3, 1'b1};
      tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b1};
      tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b1};

      for (int i = 0; i < 14; i++) begin
         reset = tbl[i].rst;
         av8   = tbl[i].av;
         a8    = tbl[i].a;
         xr8   = tbl[i].xr;
         tick();
         chk($sformatf("tbl%0d_count", i),   64'(cnt8), 64'(tbl[i].e_cnt));
         chk($sformatf("tbl%0d_xvalid", i),  64'(xv8),  64'(tbl[i].e_xv));
         chk($sformatf("tbl%0d_X", i),       64'(x8),   64'(tbl[i].e_x));
         chk($sformatf("tbl%0d_aready", i),  64'(ar8),  64'(tbl[i].e_ar));
      end
      reset = 1'b0; av8 = 1'b0; xr8 = 1'b0;

      // Streaming: push and pop every cycle, X trails A by one edge.
      pulse_reset();
      for (int i = 0; i < 20; i++) begin
         av8 = 1'b1; xr8 = 1'b1; a8 = 8'h30 + 8'(i);
         tick();
         chk($sformatf("stream%0d_count", i), 64'(cnt8), 64'd1);
         chk($sformatf("stream%0d_X", i),     64'(x8),   64'(8'h30 + 8'(i)));
      end
      av8 = 1'b0;
      tick();
      chk("stream_drain_count", 64'(cnt8), 64'd0);
      xr8 = 1'b0;

      // Reset with three entries held and a write pending.
      pulse_reset();
      for (int i = 0; i < 3; i++) begin
         av8 = 1'b1; a8 = 8'hB0 + 8'(i);
         tick();
      end
      chk("prerst_count", 64'(cnt8), 64'd3);
      reset = 1'b1; av8 = 1'b1; a8 = 8'h77;
      tick();
      reset = 1'b0;
      av8 = 1'b0;
      chk("midrst_count",  64'(cnt8), 64'd0);
      chk("midrst_xvalid", 64'(xv8),  64'd0);
      chk("midrst_X",      64'(x8),   64'd0);
      av8 = 1'b1; a8 = 8'h5C;
      tick();
      av8 = 1'b0;
      chk("postrst_X",     64'(x8),   64'h5C);
      chk("postrst_count", 64'(cnt8), 64'd1);
      xr8 = 1'b1;
      tick();
      xr8 = 1'b0;
      chk("postrst_empty", 64'(xv8),  64'd0);

      // WIDTH=1 DEPTH=2: pop while full does not admit a same-cycle push.
      pulse_reset();
      av1 = 1'b1; a1 = 1'b1;
      tick();
      a1 = 1'b0;
      tick();
      chk("w1_full_count",  64'(cnt1), 64'd2);
      chk("w1_full_aready", 64'(ar1),  64'd0);
      chk("w1_full_X",      64'(x1),   64'd1);
      av1 = 1'b1; a1 = 1'b1; xr1 = 1'b1;
      tick();
      chk("w1_popfull_count",  64'(cnt1), 64'd1);
      chk("w1_popfull_aready", 64'(ar1),  64'd1);
      chk("w1_popfull_X",      64'(x1),   64'd0);
      av1 = 1'b0;
      tick();
      xr1 = 1'b0;
      chk("w1_drain_count",  64'(cnt1), 64'd0);
      chk("w1_drain_xvalid", 64'(xv1),  64'd0);

      // Random traffic on DEPTH=3 against a queue model.
      pulse_reset();
      q3.delete();
      for (int i = 0; i < 300; i++) begin
         av3 = ($urandom_range(0, 3) != 0);
         a3  = 8'($urandom);
         xr3 = ($urandom_range(0, 1) != 0);
         m_push = av3 && (q3.size() < 3);
         m_pop  = xr3 && (q3.size() != 0);
         tick();
         if (m_pop)  void'(q3.pop_front());
         if (m_push) q3.push_back(a3);
         chk($sformatf("rnd%0d_count", i),  64'(cnt3), 64'(q3.size()));
         chk($sformatf("rnd%0d_xvalid", i), 64'(xv3),  64'(q3.size() != 0));
         chk($sformatf("rnd%0d_X", i),      64'(x3),   64'((q3.size() != 0) ? q3[0] : 8'h00));
         chk($sformatf("rnd%0d_aready", i), 64'(ar3),  64'(q3.size() < 3));
         chk($sformatf("rnd%0d_bound", i),  64'(cnt3 <= 2'd3), 64'd1);
      end
      av3 = 1'b0; xr3 = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
